reg_wb_ctrl: RTL

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_ctrl_pkg.sv | 15 +
 rtl/reg_wb_ctrl_wb_fifo2.sv | 55 +++++
 rtl/reg_wb_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared definitions for the register write-back controller.
// Holds the register-index width, the LSU FIFO depth and the write-source select encoding.
package reg_wb_ctrl_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO
  } wb_sel_e;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo2.sv
// wb_fifo2: two-entry FIFO buffering LSU write-back results (destination index + data).
// The caller never pushes when full and never pops when empty. Pointers are one bit wide,
// so they wrap modulo 2 on their own.
module wb_fifo2
  import reg_wb_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_IDX_W-1:0]  push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [REG_IDX_W-1:0]  head_rd,
  output logic [XLEN-1:0]       head_data
);

  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [REG_IDX_W-1:0] rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0]      data_mem [FIFO_DEPTH];

  // Storage write. Entries are only read once count says they are valid.
  // NOTE: storage is deliberately left out of reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-back arbiter with a pending-write scoreboard.
// ALU results are written unbuffered; LSU results pass through a 2-entry FIFO that takes
// priority only when full. Optional forwarding from the write port is enabled by defining
// the macro REG_WB_FWD_EN; without it the fwd_* outputs are tied to 0.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 regwrite,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_data,
  output logic                 fwd_rs1_hit,
  output logic                 fwd_rs2_hit,
  output logic [XLEN-1:0]      fwd_rs1_data,
  output logic [XLEN-1:0]      fwd_rs2_data
);

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [REG_IDX_W-1:0]  head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_sel_e               sel;
  logic [REG_IDX_W-1:0]  sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [NREG-1:0]       pending_q;
  logic [NREG-1:0]       pending_d;

  assign fifo_full = (fifo_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign lsu_ready = !fifo_full;
  assign alu_ready = !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready;
  assign fifo_pop  = (sel == SEL_FIFO);

  wb_fifo2 #(.XLEN(XLEN)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_rd   (lsu_rd),
    .push_data (lsu_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head_rd   (head_rd),
    .head_data (head_data)
  );

  // Source arbitration: a full FIFO drains first, then the ALU, then any buffered LSU result.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel      = SEL_NONE;
    sel_rd   = head_rd;
    sel_data = head_data;
    if (fifo_full) begin
      sel = SEL_FIFO;
    end else if (alu_valid) begin
      sel      = SEL_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (fifo_count != '0) begin
      sel = SEL_FIFO;
    end
  end

  // Registered write port; x0 writes are consumed silently, idle cycles hold rd/rd_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      rd       <= '0;
      rd_data  <= '0;
    end else begin
      regwrite <= (sel != SEL_NONE) && (sel_rd != '0);
      if (sel != SEL_NONE) begin
        rd      <= sel_rd;
        rd_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: a FIFO write clears its bit, a new issue sets one (set wins).
  always_comb begin
    pending_d = pending_q;
    if (sel == SEL_FIFO) pending_d[head_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rs1_busy = pending_q[rs1];
  assign rs2_busy = pending_q[rs2];

`ifdef REG_WB_FWD_EN
  assign fwd_rs1_hit  = regwrite && (rd == rs1) && (rs1 != '0);
  assign fwd_rs2_hit  = regwrite && (rd == rs2) && (rs2 != '0);
  assign fwd_rs1_data = rd_data;
  assign fwd_rs2_data = rd_data;
`else
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule
